// File: rtl/sad_neuron_integrator.sv
// Windowed saturating integrator with threshold spike and refractory hold-off.
// Build option NEURON_LEAK_EN adds a leak_shift input and a multiplicative leak per accepted sample.
module sad_neuron_integrator #(
  parameter int SUM_W   = 8,
  parameter int ACC_W   = 12,
  parameter int WINDOW  = 8,
  parameter int REFRACT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef NEURON_LEAK_EN
  input  logic [1:0]       leak_shift,
`endif
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] sum_in,
  output logic             sum_ready,
  input  logic [ACC_W-1:0] threshold,
  output logic             spike,
  output logic             window_done,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_DECIDE  = 2'd2,
    S_REFRACT = 2'd3
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX     = '1;
  localparam logic [7:0]       WIN_LAST    = 8'(WINDOW - 1);
  localparam logic [7:0]       REF_LAST    = 8'(REFRACT - 1);
  localparam bit               HAS_REFRACT = (REFRACT > 0);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       ref_q, ref_d;
  logic             sat_q, sat_d;
  logic             spike_q, spike_d;
  logic             done_q, done_d;

  logic             xfer;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             clip;
  logic [ACC_W-1:0] acc_next;

  // Handshake: a sample moves when sum_valid and sum_ready are both high at a
  // rising edge. sum_ready decodes only the state register, so upstream must
  // hold sum_in/sum_valid stable until it sees the transfer.
  assign sum_ready = (state_q == S_ACCUM);
  assign xfer      = sum_valid & sum_ready;

`ifdef NEURON_LEAK_EN
  assign acc_base = acc_q - (acc_q >> ({1'b0, leak_shift} + 3'd1));
`else
  assign acc_base = acc_q;
`endif

  assign acc_sum  = {1'b0, acc_base} + {{(ACC_W + 1 - SUM_W){1'b0}}, sum_in};
  assign clip     = acc_sum[ACC_W];
  assign acc_next = clip ? ACC_MAX : acc_sum[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    sat_d   = sat_q;
    spike_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_ACCUM;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
      S_ACCUM: begin
        if (xfer) begin
          acc_d = acc_next;
          cnt_d = cnt_q + 8'd1;
          if (clip) sat_d = 1'b1;
          // Decide on the closing sample so spike/window_done are registered in DECIDE.
          if (cnt_q == WIN_LAST) begin
            state_d = S_DECIDE;
            done_d  = 1'b1;
            spike_d = (acc_next >= threshold);
          end
        end
      end
      S_DECIDE: begin
        acc_d = '0;
        cnt_d = '0;
        sat_d = 1'b0;
        ref_d = '0;
        if (spike_q && HAS_REFRACT) state_d = S_REFRACT;
        else                        state_d = S_ACCUM;
      end
      S_REFRACT: begin
        if (ref_q == REF_LAST) state_d = S_ACCUM;
        else                   ref_d   = ref_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      sat_q   <= 1'b0;
      spike_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      sat_q   <= sat_d;
      spike_q <= spike_d;
      done_q  <= done_d;
    end
  end

  assign spike       = spike_q;
  assign window_done = done_q;
  assign acc_out     = acc_q;
  assign sat         = sat_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sad_neuron_integrator.sv
// Directed bench for sad_neuron_integrator: a 12-bit and a 10-bit accumulator instance.
// With NEURON_LEAK_EN defined only the reset and leak sequences are exercised.
module tb_sad_neuron_integrator;

  localparam int SUM_W = 8;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACCUM = 2'd1, ST_REFRACT = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             sum_valid = 1'b0;
  logic [SUM_W-1:0] sum_in = '0;
  logic [11:0]      threshold = '0;
  logic             sum_ready, spike, window_done, sat;
  logic [11:0]      acc_out;
  logic [1:0]       state_dbg;

  logic             sum_valid10 = 1'b0;
  logic [SUM_W-1:0] sum_in10 = '0;
  logic [9:0]       thr10 = 10'h3FF;
  logic             sum_ready10, spike10, window_done10, sat10;
  logic [9:0]       acc_out10;
  logic [1:0]       state_dbg10;

  logic [1:0]       leak_shift = 2'd0;

  sad_neuron_integrator #(.SUM_W(8), .ACC_W(12), .WINDOW(8), .REFRACT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef NEURON_LEAK_EN
    .leak_shift(leak_shift),
`endif
    .sum_valid(sum_valid), .sum_in(sum_in), .sum_ready(sum_ready),
    .threshold(threshold), .spike(spike), .window_done(window_done),
    .acc_out(acc_out), .sat(sat), .state_dbg(state_dbg)
  );

  sad_neuron_integrator #(.SUM_W(8), .ACC_W(10), .WINDOW(8), .REFRACT(4)) u_dut10 (
    .clk(clk), .rst_n(rst_n),
`ifdef NEURON_LEAK_EN
    .leak_shift(leak_shift),
`endif
    .sum_valid(sum_valid10), .sum_in(sum_in10), .sum_ready(sum_ready10),
    .threshold(thr10), .spike(spike10), .window_done(window_done10),
    .acc_out(acc_out10), .sat(sat10), .state_dbg(state_dbg10)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send(input logic [SUM_W-1:0] v);
    int guard;
    guard = 0;
    sum_valid = 1'b1;
    sum_in    = v;
    while (sum_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: sum_ready stuck at %b, required 1", sum_ready);
    end
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  task automatic send10(input logic [SUM_W-1:0] v);
    int guard;
    guard = 0;
    sum_valid10 = 1'b1;
    sum_in10    = v;
    while (sum_ready10 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL send10_timeout: sum_ready stuck at %b, required 1", sum_ready10);
    end
    @(negedge clk);
    sum_valid10 = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_acc"},   32'(acc_out),   32'd0);
    check({tag, "_spike"}, 32'(spike),     32'd0);
    check({tag, "_done"},  32'(window_done), 32'd0);
    check({tag, "_sat"},   32'(sat),       32'd0);
    check({tag, "_ready"}, 32'(sum_ready), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst_n = 1'b1;

`ifdef NEURON_LEAK_EN
    // leak_shift=0 halves the membrane before each add
    leak_shift = 2'd0;
    threshold  = 12'hFFF;
    exp_q = '{32'd64, 32'd96, 32'd112, 32'd120};
    for (int i = 0; i < 4; i++) begin
      send(8'd64);
      check($sformatf("leak_acc%0d", i), 32'(acc_out), exp_q.pop_front());
    end
`else
    // Window at exactly the threshold fires, then four refractory cycles
    threshold = 12'd80;
    for (int i = 0; i < 8; i++) begin
      send(8'd10);
      if (i == 3) check("t1_acc_mid", 32'(acc_out), 32'd40);
      if (i == 6) check("t1_done_early", 32'(window_done), 32'd0);
    end
    check("t1_acc", 32'(acc_out), 32'd80);
    check("t1_done", 32'(window_done), 32'd1);
    check("t1_spike", 32'(spike), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("t1_refract_ready%0d", k), 32'(sum_ready), 32'd0);
      if (k == 0) begin
        check("t1_spike_pulse", 32'(spike), 32'd0);
        check("t1_acc_clear", 32'(acc_out), 32'd0);
      end
    end
    @(negedge clk);
    check("t1_ready_back", 32'(sum_ready), 32'd1);

    // One above the sum: decision without spike, straight back to accumulating
    threshold = 12'd81;
    for (int i = 0; i < 8; i++) send(8'd10);
    check("t2_acc", 32'(acc_out), 32'd80);
    check("t2_done", 32'(window_done), 32'd1);
    check("t2_spike", 32'(spike), 32'd0);
    @(negedge clk);
    check("t2_ready", 32'(sum_ready), 32'd1);
    check("t2_acc_clear", 32'(acc_out), 32'd0);
    check("t2_done_pulse", 32'(window_done), 32'd0);

    // Full-scale samples: 2040 fits in 12 bits, clips at 1023 in 10 bits
    threshold = 12'd0;
    for (int i = 0; i < 8; i++) send(8'd255);
    check("t3_acc12", 32'(acc_out), 32'd2040);
    check("t3_sat12", 32'(sat), 32'd0);
    check("t3_spike12", 32'(spike), 32'd1);
    for (int i = 0; i < 8; i++) begin
      send10(8'd255);
      if (i == 3) begin
        check("t3_acc10_mid", 32'(acc_out10), 32'd1020);
        check("t3_sat10_mid", 32'(sat10), 32'd0);
      end
      if (i == 4) check("t3_sat10_set", 32'(sat10), 32'd1);
    end
    check("t3_acc10", 32'(acc_out10), 32'd1023);
    check("t3_sat10", 32'(sat10), 32'd1);
    check("t3_done10", 32'(window_done10), 32'd1);
    check("t3_spike10_max_thr", 32'(spike10), 32'd1);
    @(negedge clk);
    check("t3_sat10_clear", 32'(sat10), 32'd0);
    check("t3_acc10_clear", 32'(acc_out10), 32'd0);

    // Valid toggling: bubbles leave the accumulator untouched
    threshold = 12'd41;
    for (int i = 0; i < 8; i++) begin
      send(8'd5);
      if (i < 7) begin
        @(negedge clk);
        check($sformatf("t4_gap_acc%0d", i), 32'(acc_out), 32'(5 * (i + 1)));
        check($sformatf("t4_gap_done%0d", i), 32'(window_done), 32'd0);
      end
    end
    check("t4_acc", 32'(acc_out), 32'd40);
    check("t4_done", 32'(window_done), 32'd1);
    check("t4_spike", 32'(spike), 32'd0);

    // Reset part-way through a window discards the partial count
    for (int i = 0; i < 5; i++) send(8'd10);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("t5_mid");
    rst_n = 1'b1;
    threshold = 12'd80;
    for (int i = 0; i < 8; i++) begin
      send(8'd10);
      if (i == 6) check("t5_fresh_count", 32'(window_done), 32'd0);
    end
    check("t5_done", 32'(window_done), 32'd1);
    check("t5_spike", 32'(spike), 32'd1);
    @(negedge clk);
    check("t5_in_refract", 32'(state_dbg), 32'(ST_REFRACT));
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("t5_ref");
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_accum_after_rst", 32'(state_dbg), 32'(ST_ACCUM));
    threshold = 12'd81;
    for (int i = 0; i < 8; i++) begin
      send(8'd10);
      if (i == 6) check("t5b_done_early", 32'(window_done), 32'd0);
    end
    check("t5b_done", 32'(window_done), 32'd1);
    check("t5b_acc", 32'(acc_out), 32'd80);

    // Without leak the membrane ramps linearly
    threshold = 12'hFFF;
    exp_q = '{32'd64, 32'd128, 32'd192, 32'd256};
    for (int i = 0; i < 4; i++) begin
      send(8'd64);
      check($sformatf("ramp_acc%0d", i), 32'(acc_out), exp_q.pop_front());
    end
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case a wait loop is ever broken
  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sad_neuron_integrator.md
Name: sad_neuron_integrator

Overview:
Downstream consumer of the 8-bit fast-adder sum stage in the neuron SAD datapath. Integrates a window of registered 8-bit sums into a saturating membrane accumulator. At window end it compares against a programmable threshold, emits a one-cycle spike, then holds off input for a refractory period. Valid/ready handshake toward the adder stage.

Parameters:
SUM_W, 8, width of incoming sum samples
ACC_W, 12, accumulator (membrane) width; must be > SUM_W
WINDOW, 8, samples integrated per decision window (1..255)
REFRACT, 4, refractory cycles after a spike (0..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
sum_valid  input  1  sum_in holds a valid sample this cycle
sum_in  input  SUM_W  unsigned sample from adder stage
sum_ready  output  1  block accepts a sample this cycle
threshold  input  ACC_W  unsigned firing threshold, sampled at compare cycle
spike  output  1  one-cycle fire pulse
window_done  output  1  one-cycle pulse on every window decision, fire or not
acc_out  output  ACC_W  current accumulator value, registered
sat  output  1  sticky: accumulator saturated in current window

Behaviour:
- Reset (clk edge with rst_n=0, synchronous): state=IDLE, acc_out=0, sample count=0, refractory count=0, spike=0, window_done=0, sat=0, sum_ready=0. Reset mid-window or mid-refractory discards all state; no spike is emitted.
- States: IDLE, ACCUM, DECIDE, REFRACT.
- IDLE: sum_ready=0. Next cycle goes to ACCUM with acc=0, count=0.
- ACCUM: sum_ready=1. Transfer = sum_valid & sum_ready. On transfer: acc <= min(acc + sum_in, 2^ACC_W-1); if saturation clipped, sat<=1; count++. When the transfer brings count to WINDOW, go to DECIDE. No transfer: state and acc hold.
- DECIDE (1 cycle): sum_ready=0. window_done=1. If acc >= threshold (unsigned), spike=1 and next state is REFRACT (or ACCUM if REFRACT=0). Otherwise next state is ACCUM. Leaving DECIDE: acc<=0, count<=0, sat<=0.
- REFRACT: sum_ready=0, counts REFRACT cycles, then goes to ACCUM. Upstream sum_valid is ignored; the upstream stage must hold its data (handshake is not lossy).
- Outputs spike and window_done are registered and asserted exactly in the DECIDE-state cycle. Latency: the final sample transfer at edge N gives spike/window_done high in cycle N+1.
- threshold=0: every window fires. threshold=2^ACC_W-1: fires only when saturated.
- acc_out is visible every cycle and reads 0 from the cycle after DECIDE.
- No combinational path from sum_valid to sum_ready.

Optional Feature:
Macro NEURON_LEAK_EN. When defined: adds input port leak_shift [1:0]. On each ACCUM transfer, acc <= sat_add(acc - (acc >> (leak_shift+1)), sum_in), with the leak applied before the add. When leak_shift input is held, there is no leak in idle cycles. When undefined: no leak_shift port, pure integration as above. DECIDE and REFRACT are identical in both builds.

Test Plan:
- Reset, then 8 back-to-back samples of 10 with threshold=80 -> acc_out=80, window_done=1 and spike=1 in the cycle after the 8th transfer. sum_ready=0 for the next 4 cycles, then 1.
- Same stimulus with threshold=81 -> window_done=1, spike=0, sum_ready high again 1 cycle after DECIDE, acc_out=0.
- 8 samples of 255 with ACC_W=12 -> acc=2040, no saturation. Then rebuild with ACC_W=10 -> acc clips at 1023, sat=1, and sat clears after DECIDE.
- sum_valid toggled 1/0 every cycle with 8 samples of 5 -> decision occurs only after the 8th actual transfer (cycle 16). acc=40. Gaps do not change acc.
- rst_n=0 asserted after 5 samples, and separately during REFRACT -> next edge gives acc_out=0, spike=0, state IDLE. The first sample after reset starts a fresh count of 8.
- NEURON_LEAK_EN, leak_shift=0, samples of 64 -> acc sequence 64, 96, 112, 120, ... Without the macro -> 64, 128, 192, ...
